// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, legality helper.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    function automatic logic f3_illegal(input logic write, input logic [2:0] func3);
        if (write) begin
            return !(func3 == F3_SB || func3 == F3_SH || func3 == F3_SW);
        end
        return !(func3 == F3_LB || func3 == F3_LH || func3 == F3_LW ||
                 func3 == F3_LBU || func3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobes/data over two words, load extract and extend.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [7:0]  strb_c,
    output logic [63:0] wdata_c,
    output logic [31:0] ldata_c
);
    logic [3:0]  base_strb;
    logic [31:0] rsh;

    // Strobes and data span two words: bits [3:0]/[31:0] are beat0, the rest beat1.
    always_comb begin
        unique case (func3[1:0])
            2'b00:   base_strb = 4'h1;
            2'b01:   base_strb = 4'h3;
            default: base_strb = 4'hF;
        endcase
        strb_c  = {4'b0000, base_strb} << off;
        wdata_c = {32'h0, wdata} << {off, 3'b000};
        rsh     = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
        unique case (func3)
            F3_LB:   ldata_c = {{24{rsh[7]}}, rsh[7:0]};
            F3_LH:   ldata_c = {{16{rsh[15]}}, rsh[15:0]};
            F3_LBU:  ldata_c = {24'h0, rsh[7:0]};
            F3_LHU:  ldata_c = {16'h0, rsh[15:0]};
            default: ldata_c = rsh;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store initiator for a word-addressed, byte-strobed data memory.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses into two beats instead of erroring.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        func3_q, func3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              split_q, split_d;
    logic [31:0]       rdata_lo_q, rdata_lo_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              idle, in_wait1, illegal, misaligned;
    logic              f_write;
    logic [2:0]        f_func3;
    logic [ADDR_W-1:0] f_addr, word_addr;
    logic [31:0]       f_wdata, al_lo, al_hi, ldata;
    logic [7:0]        strb8;
    logic [63:0]       wdata64;

    // In IDLE the incoming request feeds decode so the first beat is ready at accept.
    assign idle      = (state_q == ST_IDLE);
    assign in_wait1  = (state_q == ST_WAIT1);
    assign f_write   = idle ? req_write : write_q;
    assign f_func3   = idle ? req_func3 : func3_q;
    assign f_addr    = idle ? req_addr  : addr_q;
    assign f_wdata   = idle ? req_wdata : wdata_q;
    assign word_addr = {f_addr[ADDR_W-1:2], 2'b00};
    assign illegal   = f3_illegal(f_write, f_func3);
    assign misaligned = (f_func3[1:0] == 2'b10 && f_addr[1:0] != 2'b00) ||
                        (f_func3[1:0] == 2'b01 && f_addr[1:0] == 2'b11);
    assign al_lo     = in_wait1 ? rdata_lo_q : mem_rdata;
    assign al_hi     = in_wait1 ? mem_rdata  : 32'h0;

    lsu_align u_align (
        .func3    (f_func3),
        .off      (f_addr[1:0]),
        .wdata    (f_wdata),
        .rdata_lo (al_lo),
        .rdata_hi (al_hi),
        .strb_c   (strb8),
        .wdata_c  (wdata64),
        .ldata_c  (ldata)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        func3_d      = func3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        split_d      = split_q;
        rdata_lo_d   = rdata_lo_q;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    split_d = 1'b0;
                    if (illegal) begin
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                    end else if (misaligned) begin
`ifdef MISALIGNED_SPLIT_EN
                        split_d = 1'b1;
                        state_d = ST_REQ0;
`else
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
`endif
                    end else begin
                        state_d = ST_REQ0;
                    end
                end
            end
            ST_REQ0:  if (mem_gnt) state_d = ST_WAIT0;
            ST_WAIT0: begin
                if (mem_rvalid) begin
                    rdata_lo_d = mem_rdata;
                    if (split_q) begin
                        state_d = ST_REQ1;
                    end else begin
                        state_d      = ST_RESP;
                        resp_rdata_d = write_q ? 32'h0 : ldata;
                    end
                end
            end
            ST_REQ1:  if (mem_gnt) state_d = ST_WAIT1;
            ST_WAIT1: begin
                if (mem_rvalid) begin
                    state_d      = ST_RESP;
                    resp_rdata_d = write_q ? 32'h0 : ldata;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered versions of what the next state presents.
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        mem_req_d    = (state_d == ST_REQ0) || (state_d == ST_REQ1);
        mem_we_d     = mem_req_d & f_write;
        mem_addr_d   = '0;
        mem_wstrb_d  = 4'h0;
        mem_wdata_d  = 32'h0;
        if (state_d == ST_REQ0) begin
            mem_addr_d  = word_addr;
            mem_wstrb_d = strb8[3:0];
            mem_wdata_d = f_write ? wdata64[31:0] : 32'h0;
        end else if (state_d == ST_REQ1) begin
            mem_addr_d  = word_addr + ADDR_W'(4);
            mem_wstrb_d = strb8[7:4];
            mem_wdata_d = f_write ? wdata64[63:32] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            func3_q      <= 3'h0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            split_q      <= 1'b0;
            rdata_lo_q   <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= 4'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            func3_q      <= func3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            split_q      <= split_d;
            rdata_lo_q   <= rdata_lo_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
